// File: rtl/tdm_mux_scanner.sv
// Registered N:1 channel multiplexer with manual select and a round-robin scan
// mode that dwells on each enabled channel; output is a valid/ready source.
module tdm_mux_scanner #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int DWELL    = 4,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [SELW-1:0]           sel,
    input  logic                      mode,
    input  logic [CHANNELS-1:0]       en_mask,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_ch,
    output logic                      out_valid,
    output logic                      scan_wrap
);

    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        MANUAL,
        SCAN_INIT,
        SCAN
    } state_t;

    state_t          state, state_nxt;
    logic [SELW-1:0] ptr, ptr_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic [SELW-1:0] ch_nxt;
    logic            valid_nxt, wrap_nxt;

    logic [SELW-1:0]  lowest, highest, next_ptr;
    logic             any_en, next_found, stall;
    logic [WIDTH-1:0] sel_data, ptr_data;
    logic             sel_en, ptr_en;

    // Matching by equality keeps out-of-range selects (non power-of-2 CHANNELS) harmless.
    always_comb begin
        lowest     = '0;
        highest    = '0;
        next_ptr   = '0;
        any_en     = 1'b0;
        next_found = 1'b0;
        sel_data   = '0;
        sel_en     = 1'b0;
        ptr_data   = '0;
        ptr_en     = 1'b0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (en_mask[k]) lowest = SELW'(k);
        end
        for (int k = 0; k < CHANNELS; k++) begin
            if (en_mask[k]) begin
                highest = SELW'(k);
                any_en  = 1'b1;
                if (!next_found && SELW'(k) > ptr) begin
                    next_ptr   = SELW'(k);
                    next_found = 1'b1;
                end
            end
            if (sel == SELW'(k)) begin
                sel_data = din[k*WIDTH +: WIDTH];
                sel_en   = en_mask[k];
            end
            if (ptr == SELW'(k)) begin
                ptr_data = din[k*WIDTH +: WIDTH];
                ptr_en   = en_mask[k];
            end
        end
        if (!next_found) next_ptr = lowest;
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        data_nxt  = out_data;
        ch_nxt    = out_ch;
        valid_nxt = out_valid;
        wrap_nxt  = 1'b0;
        stall     = out_valid & ~out_ready;
        if (!stall) valid_nxt = 1'b0;

        case (state)
            MANUAL: begin
                if (mode) state_nxt = SCAN_INIT;
                if (!stall && sel_en) begin
                    data_nxt  = sel_data;
                    ch_nxt    = sel;
                    valid_nxt = 1'b1;
                end
            end
            SCAN_INIT: begin
                ptr_nxt   = lowest;
                cnt_nxt   = '0;
                state_nxt = mode ? SCAN : MANUAL;
            end
            SCAN: begin
                // An empty mask freezes the walk entirely until a channel is re-enabled.
                if (!mode) begin
                    state_nxt = MANUAL;
                end else if (!stall && any_en) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt = '0;
                        ptr_nxt = next_ptr;
                        if (ptr_en) begin
                            data_nxt  = ptr_data;
                            ch_nxt    = ptr;
                            valid_nxt = 1'b1;
                            wrap_nxt  = (ptr == highest);
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = MANUAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MANUAL;
            ptr       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            scan_wrap <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            out_data  <= data_nxt;
            out_ch    <= ch_nxt;
            out_valid <= valid_nxt;
            scan_wrap <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_tdm_mux_scanner.sv
// Bench for tdm_mux_scanner: an 8-channel and a 6-channel instance (DWELL=2)
// share stimulus and are checked every cycle against a behavioural model.
module tb_tdm_mux_scanner;

    localparam int DW = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] din = '0;
    logic [2:0]  sel = '0;
    logic        mode = 1'b0;
    logic [7:0]  en_mask = '0;
    logic        out_ready = 1'b1;

    logic [7:0] d8, d6;
    logic [2:0] c8, c6;
    logic       v8, v6, w8, w6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdm_mux_scanner #(.WIDTH(8), .CHANNELS(8), .DWELL(DW)) dut8 (
        .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode),
        .en_mask(en_mask), .out_ready(out_ready),
        .out_data(d8), .out_ch(c8), .out_valid(v8), .scan_wrap(w8)
    );

    tdm_mux_scanner #(.WIDTH(8), .CHANNELS(6), .DWELL(DW)) dut6 (
        .clk(clk), .rst(rst), .din(din[47:0]), .sel(sel), .mode(mode),
        .en_mask(en_mask[5:0]), .out_ready(out_ready),
        .out_data(d6), .out_ch(c6), .out_valid(v6), .scan_wrap(w6)
    );

    // phase: 0 = forwarding sel, 1 = arming a new pass, 2 = walking the mask
    typedef struct {
        int       phase;
        int       ptr;
        int       cnt;
        logic [7:0] data;
        int       ch;
        bit       valid;
        bit       wrap;
    } mdl_t;

    mdl_t m8 = '{0, 0, 0, 8'h00, 0, 1'b0, 1'b0};
    mdl_t m6 = '{0, 0, 0, 8'h00, 0, 1'b0, 1'b0};

    function automatic mdl_t step(mdl_t s, int n, logic [63:0] d, int sel_v,
                                  bit mode_v, logic [7:0] mask, bit rdy, bit rst_v);
        mdl_t r;
        bit   stall;
        int   lo, hi, nx;
        r = s;
        if (rst_v) begin
            r = '{0, 0, 0, 8'h00, 0, 1'b0, 1'b0};
            return r;
        end
        lo = -1; hi = -1; nx = -1;
        for (int k = 0; k < n; k++) begin
            if (mask[k]) begin
                if (lo < 0) lo = k;
                hi = k;
                if (k > s.ptr && nx < 0) nx = k;
            end
        end
        if (nx < 0) nx = lo;
        stall  = s.valid && !rdy;
        r.wrap = 1'b0;
        if (!stall) r.valid = 1'b0;
        if (s.phase == 0) begin
            if (mode_v) r.phase = 1;
            if (!stall && sel_v < n && mask[sel_v]) begin
                r.data  = d[sel_v*8 +: 8];
                r.ch    = sel_v;
                r.valid = 1'b1;
            end
        end else if (s.phase == 1) begin
            r.ptr   = (lo < 0) ? 0 : lo;
            r.cnt   = 0;
            r.phase = mode_v ? 2 : 0;
        end else begin
            if (!mode_v) begin
                r.phase = 0;
            end else if (!stall && lo >= 0) begin
                if (s.cnt == DW - 1) begin
                    r.cnt = 0;
                    r.ptr = nx;
                    if (mask[s.ptr]) begin
                        r.data  = d[s.ptr*8 +: 8];
                        r.ch    = s.ptr;
                        r.valid = 1'b1;
                        r.wrap  = (s.ptr == hi);
                    end
                end else begin
                    r.cnt = s.cnt + 1;
                end
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        m8 = step(m8, 8, din, int'(sel), mode, en_mask, out_ready, rst);
        m6 = step(m6, 6, din, int'(sel), mode, en_mask, out_ready, rst);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        chk("m8_valid", 32'(v8), 32'(m8.valid));
        chk("m8_data",  32'(d8), 32'(m8.data));
        chk("m8_ch",    32'(c8), m8.ch);
        chk("m8_wrap",  32'(w8), 32'(m8.wrap));
        chk("m6_valid", 32'(v6), 32'(m6.valid));
        chk("m6_data",  32'(d6), 32'(m6.data));
        chk("m6_ch",    32'(c6), m6.ch);
        chk("m6_wrap",  32'(w6), 32'(m6.wrap));
    endtask

    always @(negedge clk) checkOutput();

    task automatic applyStimulus(input logic [63:0] d, input logic [2:0] s, input logic m,
                                 input logic [7:0] mk, input logic r);
        din       = d;
        sel       = s;
        mode      = m;
        en_mask   = mk;
        out_ready = r;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    logic [63:0] pat;
    int   got[$];
    bit   wr[$];
    int   at[$];
    bit   found;

    initial begin
        for (int k = 0; k < 8; k++) pat[k*8 +: 8] = 8'h10 + 8'(k);

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus({$urandom, $urandom}, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          8'($urandom), 1'($urandom_range(0, 1)));
            tick(1);
        end
        chk("reset_data", 32'(d8), 0);
        chk("reset_ch", 32'(c8), 0);
        chk("reset_valid", 32'(v8), 0);
        chk("reset_wrap", 32'(w8), 0);

        rst = 1'b0;
        applyStimulus(pat, 3'd5, 1'b0, 8'hFF, 1'b1);
        tick(1);
        chk("manual_data", 32'(d8), 32'h15);
        chk("manual_ch", 32'(c8), 5);
        chk("manual_valid", 32'(v8), 1);

        applyStimulus(pat, 3'd7, 1'b0, 8'hFF, 1'b1);
        tick(1);
        chk("range_valid6", 32'(v6), 0);
        chk("range_data8", 32'(d8), 32'h17);

        // full-mask scan
        applyStimulus(pat, 3'd7, 1'b1, 8'hFF, 1'b1);
        tick(2);
        got.delete(); wr.delete(); at.delete();
        for (int i = 0; i < 40 && got.size() < 9; i++) begin
            tick(1);
            if (v8) begin
                got.push_back(int'(c8));
                wr.push_back(w8);
                at.push_back(i);
            end
        end
        chk("full_count", got.size(), 9);
        if (at.size() > 0) chk("full_latency", at[0], 1);
        for (int i = 0; i < got.size(); i++) begin
            chk("full_ch", got[i], i % 8);
            chk("full_wrap", 32'(wr[i]), 32'(i % 8 == 7));
            if (i > 0) chk("full_spacing", at[i] - at[i-1], DW);
        end

        // sparse mask, fresh pass
        applyStimulus(pat, 3'd0, 1'b0, 8'hA4, 1'b1);
        tick(2);
        applyStimulus(pat, 3'd0, 1'b1, 8'hA4, 1'b1);
        tick(2);
        got.delete(); wr.delete();
        for (int i = 0; i < 40 && got.size() < 4; i++) begin
            tick(1);
            if (v8) begin
                got.push_back(int'(c8));
                wr.push_back(w8);
            end
        end
        chk("sparse_count", got.size(), 4);
        for (int i = 0; i < got.size(); i++) begin
            chk("sparse_ch", got[i], (i % 3 == 0) ? 2 : (i % 3 == 1) ? 5 : 7);
            chk("sparse_wrap", 32'(wr[i]), 32'(i % 3 == 2));
        end

        // backpressure while ch3 is on the output
        applyStimulus(pat, 3'd0, 1'b1, 8'hFF, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            found = m8.valid && m8.ch == 3;
        end
        chk("stall_reach", 32'(found), 1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("stall_data", 32'(d8), 32'h13);
            chk("stall_ch", 32'(c8), 3);
            chk("stall_valid", 32'(v8), 1);
        end
        out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            tick(1);
            found = v8;
        end
        chk("stall_resume_seen", 32'(found), 1);
        chk("stall_resume_ch", 32'(c8), 4);

        // clear ch4 during its dwell on the 6-channel instance
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            found = m6.phase == 2 && m6.ptr == 4 && m6.cnt == 0;
        end
        chk("skip_reach", 32'(found), 1);
        en_mask = 8'hEF;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick(1);
            found = v6;
        end
        chk("skip_seen", 32'(found), 1);
        chk("skip_ch", 32'(c6), 5);

        // reset while scanning and stalled
        applyStimulus(pat, 3'd0, 1'b1, 8'hFF, 1'b0);
        tick(5);
        rst = 1'b1;
        tick(1);
        chk("midreset_valid", 32'(v8), 0);
        chk("midreset_data", 32'(d8), 0);
        chk("midreset_ch", 32'(c8), 0);
        rst = 1'b0;

        for (int i = 0; i < 500; i++) begin
            din = {$urandom, $urandom};
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0)
                en_mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
